hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
Parametrised load-use hazard and stall controller for the 5-stage MIPS pipeline, sitting between the IF/ID and ID/EX pipeline registers and the PC.
- Detects load-use hazards, excluding register $0 and operands that do not read Rt.
- Holds the front end for a configurable number of bubble cycles per hazard.
- Freezes the whole pipeline while data memory is busy.
- Flushes IF/ID on a taken branch.
- Keeps a saturating count of stall cycles for performance checks.

Parameters:
REG_ADDR_W, 5, register-specifier width.
LOAD_LATENCY, 1, bubbles inserted per load-use hazard; legal range 1..7.
CNT_W, 16, width of the stall-cycle performance counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
ID_EX_MemRead  input  1  instruction in EX is a load.
ID_EX_RegisterRt  input  REG_ADDR_W  load destination register.
IF_ID_RegisterRs  input  REG_ADDR_W  Rs of instruction in ID.
IF_ID_RegisterRt  input  REG_ADDR_W  Rt of instruction in ID.
IF_ID_UsesRt  input  1  ID instruction reads Rt (R-type, store, beq).
branchTaken  input  1  branch resolved taken in ID this cycle.
memBusy  input  1  data memory not ready; pipeline must hold.
stall  output  1  insert bubble: zero ID/EX control signals.
pcWrite  output  1  PC write enable, 1 = update PC.
IF_ID_Write  output  1  IF/ID write enable, 1 = load.
IF_ID_Flush  output  1  clear IF/ID to NOP at next edge.
pipeFreeze  output  1  hold ID/EX, EX/MEM, MEM/WB.
stallCount  output  CNT_W  saturating count of stall/freeze cycles.

Behaviour:
- hz (combinational) = ID_EX_MemRead && ID_EX_RegisterRt != 0 && (ID_EX_RegisterRt == IF_ID_RegisterRs || (IF_ID_UsesRt && ID_EX_RegisterRt == IF_ID_RegisterRt)).
- Enable polarity is active-high. Default outputs: pcWrite=1, IF_ID_Write=1, stall=0, IF_ID_Flush=0, pipeFreeze=0.
- FSM states: RUN, LOAD_STALL, MEM_WAIT. Down-counter cnt has width clog2(LOAD_LATENCY+1).
- Outputs are combinational from state and inputs. While reset=1 they are forced to the default values.
- Reset: state=RUN, cnt=0, stallCount=0. Reset asserted mid-stall or mid-freeze aborts it; the first cycle after reset is RUN.
- Priority in RUN: memBusy, then hz, then branchTaken.
- RUN, memBusy=1:
  - Outputs: pipeFreeze=1, pcWrite=0, IF_ID_Write=0, stall=0.
  - Next state MEM_WAIT.
- RUN, hz=1:
  - Outputs same cycle: stall=1, pcWrite=0, IF_ID_Write=0.
  - LOAD_LATENCY=1: stay in RUN; the bubble in ID/EX clears hz next cycle.
  - LOAD_LATENCY>1: go to LOAD_STALL with cnt=LOAD_LATENCY-1.
- LOAD_STALL:
  - Outputs: stall=1, pcWrite=0, IF_ID_Write=0. hz is ignored.
  - cnt decrements each cycle; when cnt==1, next state is RUN.
  - memBusy=1 here: go to MEM_WAIT, cnt held, and resume LOAD_STALL afterwards.
- MEM_WAIT:
  - Outputs: pipeFreeze=1, pcWrite=0, IF_ID_Write=0, stall=0, IF_ID_Flush=0.
  - Exit on the first cycle memBusy=0: go to LOAD_STALL if cnt!=0, else RUN.
  - That exit cycle is evaluated as the destination state.
- RUN, branchTaken=1 with no hz and no memBusy:
  - IF_ID_Flush=1 for exactly one cycle; pcWrite=1.
  - branchTaken during a stall or freeze is ignored; ID re-asserts it once the stall ends.
- stallCount increments on each non-reset cycle where stall|pipeFreeze. It saturates at 2^CNT_W-1 with no wrap.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - REG_ADDR_W.
  - REG_ZERO constant.
  - FSM state enum hz_state_t {RUN, LOAD_STALL, MEM_WAIT}.
- One natural sub-module: sat_counter (parametrised width, enable, synchronous clear), used for stallCount.

Test Plan:
- Load-use on Rs: LOAD_LATENCY=1, ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 -> stall=1, pcWrite=0, IF_ID_Write=0 for exactly 1 cycle; stallCount=1.
- No false hazards:
  - ID_EX_Rt=0 with IF_ID_Rs=0 -> no stall.
  - ID_EX_Rt=9, IF_ID_Rt=9, IF_ID_UsesRt=0 -> no stall.
- Multi-bubble: LOAD_LATENCY=3, hazard on Rt=12 with UsesRt=1 -> stall high for 3 consecutive cycles, then pcWrite=1; stallCount=3.
- Freeze inside stall: LOAD_LATENCY=3, memBusy=1 for 2 cycles starting on the 2nd bubble -> pipeFreeze 2 cycles, then 2 remaining bubbles; stallCount=5.
- Branch versus hazard:
  - branchTaken with hz=1 -> IF_ID_Flush=0, stall=1.
  - branchTaken alone -> IF_ID_Flush=1 for 1 cycle.
- Reset mid-LOAD_STALL (LOAD_LATENCY=4, reset on bubble 2) -> the next cycle has default outputs and stallCount=0. Also drive stallCount to max with CNT_W=4 -> it holds at 15.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard/stall logic.
package mips_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  // Register $0 is hardwired to zero, so it never carries a real dependency.
  localparam int unsigned REG_ZERO   = 0;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment until all ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use hazard detection, multi-bubble stall, memory freeze and branch flush control.
module hazard_stall_controller #(
  parameter int unsigned REG_ADDR_W   = mips_pipe_pkg::REG_ADDR_W,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRt,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
  input  logic                  IF_ID_UsesRt,
  input  logic                  branchTaken,
  input  logic                  memBusy,
  output logic                  stall,
  output logic                  pcWrite,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  pipeFreeze,
  output logic [CNT_W-1:0]      stallCount
);

  import mips_pipe_pkg::*;

  localparam int unsigned CntW = $clog2(LOAD_LATENCY + 1);
  // The hazard cycle itself is the first bubble, so LOAD_STALL covers the rest.
  localparam logic [CntW-1:0] CntInit = CntW'(LOAD_LATENCY - 1);

  hz_state_t       state_q, state_d, eval_st;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hz;

  assign hz = ID_EX_MemRead &&
              (ID_EX_RegisterRt != REG_ADDR_W'(REG_ZERO)) &&
              ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
               (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

  // Next-state and output decode; the MEM_WAIT exit cycle behaves as its destination state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    pcWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    pipeFreeze  = 1'b0;

    eval_st = state_q;
    if ((state_q == MEM_WAIT) && !memBusy) begin
      eval_st = (cnt_q != '0) ? LOAD_STALL : RUN;
    end

    if (!reset) begin
      unique case (eval_st)
        RUN: begin
          if (memBusy) begin
            pipeFreeze  = 1'b1;
            pcWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            state_d     = MEM_WAIT;
          end else if (hz) begin
            stall       = 1'b1;
            pcWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            state_d     = RUN;
            if (LOAD_LATENCY > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = CntInit;
            end
          end else begin
            IF_ID_Flush = branchTaken;
            state_d     = RUN;
          end
        end
        LOAD_STALL: begin
          pcWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          if (memBusy) begin
            // Freeze without consuming a bubble; cnt resumes after the wait.
            pipeFreeze = 1'b1;
            state_d    = MEM_WAIT;
          end else begin
            stall   = 1'b1;
            cnt_d   = cnt_q - CntW'(1);
            state_d = (cnt_q == CntW'(1)) ? RUN : LOAD_STALL;
          end
        end
        MEM_WAIT: begin
          pipeFreeze  = 1'b1;
          pcWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          state_d     = MEM_WAIT;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and bubble-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk),
    .clr_i   (reset),
    .en_i    (stall | pipeFreeze),
    .count_o (stallCount)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: three instances (latency 1/3/4) share stimulus.
module tb_hazard_stall_controller;

  logic       clk;
  logic       reset;
  logic       mr;
  logic [4:0] exrt, rs, rt;
  logic       uses, br, mb;

  logic        s1, p1, w1, f1, z1;
  logic        s3, p3, w3, f3, z3;
  logic        s4, p4, w4, f4, z4;
  logic [15:0] c1, c3;
  logic [3:0]  c4;

  int total = 0;
  int bad   = 0;

  int rem [3];
  int cnt [3];
  int ll_of [3];
  int max_of [3];

  typedef struct {
    logic       mr;
    logic [4:0] exrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       br;
    logic       mb;
    logic       e_stall;
    logic       e_flush;
    logic       e_freeze;
  } vec_t;

  vec_t vecs [9];

  hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .ID_EX_MemRead(mr), .ID_EX_RegisterRt(exrt),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_UsesRt(uses),
    .branchTaken(br), .memBusy(mb), .stall(s1), .pcWrite(p1), .IF_ID_Write(w1),
    .IF_ID_Flush(f1), .pipeFreeze(z1), .stallCount(c1)
  );

  hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .ID_EX_MemRead(mr), .ID_EX_RegisterRt(exrt),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_UsesRt(uses),
    .branchTaken(br), .memBusy(mb), .stall(s3), .pcWrite(p3), .IF_ID_Write(w3),
    .IF_ID_Flush(f3), .pipeFreeze(z3), .stallCount(c3)
  );

  hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .ID_EX_MemRead(mr), .ID_EX_RegisterRt(exrt),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_UsesRt(uses),
    .branchTaken(br), .memBusy(mb), .stall(s4), .pcWrite(p4), .IF_ID_Write(w4),
    .IF_ID_Flush(f4), .pipeFreeze(z4), .stallCount(c4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hz_ref();
    return mr && (exrt != 0) && ((exrt == rs) || (uses && (exrt == rt)));
  endfunction

  // Reference: memBusy always freezes; pending bubbles drain before a new hazard counts.
  function automatic logic [4:0] model_out(input int k);
    logic st, fr, fl;
    st = 1'b0;
    fr = 1'b0;
    fl = 1'b0;
    if (!reset) begin
      if (mb) fr = 1'b1;
      else if ((rem[k] > 0) || hz_ref()) st = 1'b1;
      else if (br) fl = 1'b1;
    end
    return {st, !(st | fr), !(st | fr), fl, fr};
  endfunction

  function automatic logic [20:0] dut_vec(input int k);
    case (k)
      0:       return {s1, p1, w1, f1, z1, c1};
      1:       return {s3, p3, w3, f3, z3, c3};
      default: return {s4, p4, w4, f4, z4, 12'd0, c4};
    endcase
  endfunction

  task automatic model_advance();
    logic [4:0] o;
    for (int k = 0; k < 3; k++) begin
      o = model_out(k);
      if (reset) begin
        rem[k] = 0;
        cnt[k] = 0;
      end else begin
        if (!mb) begin
          if (rem[k] > 0) rem[k] = rem[k] - 1;
          else if (hz_ref()) rem[k] = ll_of[k] - 1;
        end
        if ((o[4] || o[0]) && (cnt[k] < max_of[k])) cnt[k] = cnt[k] + 1;
      end
    end
  endtask

  // One clock: compare every instance against the model mid-cycle, then advance.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_dut%0d", k), 32'(dut_vec(k)), 32'({model_out(k), 16'(cnt[k])}));
    end
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle_inputs();
    mr = 0; exrt = 0; rs = 0; rt = 0; uses = 0; br = 0; mb = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    ll_of  = '{1, 3, 4};
    max_of = '{65535, 65535, 15};
    rem    = '{0, 0, 0};
    cnt    = '{0, 0, 0};
    vecs[0] = '{1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    chk("reset_stall", 32'(s1), 0);
    chk("reset_pcwrite", 32'(p1), 1);
    chk("reset_count", 32'(c1), 0);
    cycle();

    // Table vectors on the latency-1 instance.
    for (int i = 0; i < 9; i++) begin
      mr = vecs[i].mr; exrt = vecs[i].exrt; rs = vecs[i].rs; rt = vecs[i].rt;
      uses = vecs[i].uses; br = vecs[i].br; mb = vecs[i].mb;
      #2;
      chk($sformatf("vec%0d", i), 32'({s1, p1, w1, f1, z1}),
          32'({vecs[i].e_stall, !(vecs[i].e_stall | vecs[i].e_freeze),
               !(vecs[i].e_stall | vecs[i].e_freeze), vecs[i].e_flush, vecs[i].e_freeze}));
      cycle();
    end

    // Load-use on Rs, latency 1: one bubble, count 1.
    do_reset();
    mr = 1; exrt = 8; rs = 8;
    #2;
    chk("lu_stall", 32'({s1, p1, w1}), 32'(3'b100));
    cycle();
    idle_inputs();
    #2;
    chk("lu_after", 32'({s1, p1, w1}), 32'(3'b011));
    chk("lu_count", 32'(c1), 1);
    cycle();

    // Multi-bubble on Rt, latency 3.
    do_reset();
    mr = 1; exrt = 12; rt = 12; uses = 1; rs = 3;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("mb_stall%0d", i), 32'({s3, p3}), 32'(2'b10));
      cycle();
      idle_inputs();
    end
    #2;
    chk("mb_release", 32'({s3, p3}), 32'(2'b01));
    chk("mb_count", 32'(c3), 3);
    cycle();

    // Memory freeze arriving on the second bubble.
    do_reset();
    mr = 1; exrt = 12; rt = 12; uses = 1;
    cycle();
    idle_inputs();
    mb = 1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk($sformatf("fz_freeze%0d", i), 32'({s3, z3, p3}), 32'(3'b010));
      cycle();
    end
    mb = 0;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk($sformatf("fz_bubble%0d", i), 32'({s3, z3, p3}), 32'(3'b100));
      cycle();
    end
    #2;
    chk("fz_release", 32'({s3, z3, p3}), 32'(3'b001));
    chk("fz_count", 32'(c3), 5);
    cycle();

    // Branch versus hazard.
    do_reset();
    mr = 1; exrt = 7; rs = 7; br = 1;
    #2;
    chk("br_hz", 32'({f1, s1}), 32'(2'b01));
    cycle();
    mr = 0;
    #2;
    chk("br_alone", 32'({f1, s1, p1}), 32'(3'b101));
    cycle();
    br = 0;
    #2;
    chk("br_done", 32'(f1), 0);
    cycle();

    // Reset on the second bubble of a latency-4 stall.
    do_reset();
    mr = 1; exrt = 4; rs = 4;
    cycle();
    idle_inputs();
    reset = 1;
    #2;
    chk("rst_mid_forced", 32'({s4, p4, w4}), 32'(3'b011));
    cycle();
    reset = 0;
    #2;
    chk("rst_mid_after", 32'({s4, p4, w4, z4}), 32'(4'b0110));
    chk("rst_mid_count", 32'(c4), 0);
    cycle();

    // Saturation of the 4-bit counter.
    do_reset();
    mb = 1;
    for (int i = 0; i < 20; i++) cycle();
    mb = 0;
    #2;
    chk("sat_cnt4", 32'(c4), 15);
    chk("sat_cnt16", 32'(c1), 20);
    cycle();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      mr    = 1'($urandom_range(0, 1));
      exrt  = 5'($urandom_range(0, 3));
      rs    = 5'($urandom_range(0, 3));
      rt    = 5'($urandom_range(0, 3));
      uses  = 1'($urandom_range(0, 1));
      br    = 1'($urandom_range(0, 1));
      mb    = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 0;
    idle_inputs();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
